sprite_rle_encoder: RTL
=======================

// Module: sprite_rle_encoder
// PURPOSE
//   Streaming run-length encoder for sprite image data; the writer side of the sprite colour ROMs.
//   Takes one 12-bit pixel per handshake in raster order, index = row*WIDTH + col.
//   Emits run records {start, end, color}, with end inclusive, one per maximal run of equal colour.
//   Records feed the ROM generator / on-chip run table, which the sprite ROM decodes per (row, col).
// PARAMETERS
//   COLOR_W    12     pixel colour width
//   IMG_PIXELS 97528  pixels per frame (584 x 167); last pixel index = IMG_PIXELS-1
//   ADDR_W     17     width of pixel index / run start / run end; must satisfy 2**ADDR_W >= IMG_PIXELS
// PORTS
//   clk        in   1        system clock, all logic on rising edge
//   reset      in   1        synchronous, active-high reset
//   start      in   1        1-cycle pulse, begins a frame; honoured only in IDLE
//   pix_valid  in   1        pixel available
//   pix_ready  out  1        encoder accepts pixel this cycle
//   pix_color  in   COLOR_W  pixel colour, sampled when pix_valid && pix_ready
//   run_valid  out  1        run record valid; held until accepted
//   run_ready  in   1        downstream accepts record
//   run_start  out  ADDR_W   first pixel index of run
//   run_end    out  ADDR_W   last pixel index of run (inclusive)
//   run_color  out  COLOR_W  colour of run
//   run_last   out  1        record is the final run of the frame
//   run_count  out  ADDR_W   records handshaked this frame
//   busy       out  1        1 in any state other than IDLE
//   done       out  1        1-cycle pulse when the final record is accepted
// BEHAVIOUR
//   Reset: state=IDLE; every output = 0; the open run is discarded. Reset mid-frame abandons the frame silently.
//   FSM IDLE -> RUN -> FLUSH -> DRAIN -> IDLE.
//   IDLE: pix_ready=0. start -> RUN, pix_idx=0, open=0, run_count=0.
//   start in any state other than IDLE is ignored.
//   Output register is a single stage.
//     run_valid and all run_* fields are stable while run_valid && !run_ready.
//     The register is free this cycle when !run_valid || run_ready.
//   RUN: pix_ready = output register free. On pixel accept at index pix_idx:
//     - if open=0: open the run, start=end=pix_idx, color=pix_color.
//     - if pix_color == open color: end <= pix_idx.
//     - otherwise: load output register with the open run (run_last=0), then open a new run at pix_idx.
//     - pix_idx increments. Accepting index IMG_PIXELS-1 -> FLUSH; the index never wraps.
//   FLUSH: pix_ready=0. When the output register is free, load the open run with run_last=1 -> DRAIN.
//   DRAIN: on run_valid && run_ready: done=1 for one cycle, run_valid=0 -> IDLE.
//   run_count increments on every run_valid && run_ready, including the final record.
//   Records are contiguous: next.run_start == prev.run_end + 1; the first start is 0 and the final end is IMG_PIXELS-1.
//   Adjacent records never share a colour. A run of length 1 gives run_start == run_end.
//   Latency: a record becomes valid the cycle after the pixel that closes it is accepted.
//     The final record is valid 2 cycles after the last pixel is accepted, if run_ready is high.
//   Back-to-back load: when an emit and a downstream accept fall in the same cycle, the register reloads with no bubble.
// TESTING  (IMG_PIXELS=16, ADDR_W=5 unless noted)
//   Uniform frame, all 16 pixels 0x000, run_ready=1
//     -> one record (0,15,0x000,last=1), run_count=1, done pulse, back to IDLE.
//   Pixels 0-3=0x000, 4-5=0xFFF, 6-15=0x000
//     -> records (0,3,000), (4,5,FFF), (6,15,000,last=1), run_count=3.
//   Pixels 0-14=0x000, pixel 15=0xFFF
//     -> (0,14,000,last=0) then (15,15,FFF,last=1); no record lost through FLUSH.
//   run_ready low for 10 cycles with a record pending
//     -> run_* fields stable, pix_ready=0, no pixel dropped; output matches the run_ready=1 case.
//   reset high for 1 cycle after pixel 7 is accepted
//     -> next cycle all outputs 0, busy=0; a new start encodes a fresh frame from index 0.
//   start pulsed during RUN
//     -> ignored: pix_idx and run_count continue unchanged; exactly one done per frame.

Source files
------------

// File: rtl/sprite_rle_encoder.sv
// Streaming run-length encoder for raster sprite pixels.
// Emits {start,end,color} records, one per maximal equal-colour run.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              frame start pulse (honoured in IDLE only)
//   pix_valid/ready    pixel handshake, pix_color sampled on accept
//   run_valid/ready    record handshake, run_* held while stalled
//   run_start/end      first/last (inclusive) pixel index of run
//   run_color/last     run colour, final-record-of-frame flag
//   run_count          records accepted this frame
//   busy, done         not IDLE; pulse after final record accepted
module sprite_rle_encoder #(
  parameter int COLOR_W    = 12,
  parameter int IMG_PIXELS = 97528,
  parameter int ADDR_W     = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [COLOR_W-1:0] pix_color,
  output logic               run_valid,
  input  logic               run_ready,
  output logic [ADDR_W-1:0]  run_start,
  output logic [ADDR_W-1:0]  run_end,
  output logic [COLOR_W-1:0] run_color,
  output logic               run_last,
  output logic [ADDR_W-1:0]  run_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(IMG_PIXELS - 1);

  state_t state;
  state_t state_nx;

  logic               open;
  logic [ADDR_W-1:0]  pix_idx;
  logic [ADDR_W-1:0]  cur_start;
  logic [ADDR_W-1:0]  cur_end;
  logic [COLOR_W-1:0] cur_color;

  logic free;
  logic hs;
  logic same;
  logic last_pix;
  logic acc;
  logic go;
  logic load;
  logic load_last;
  logic fin;

  // Output register can take a new record when empty
  // or being drained this very cycle (no bubble).
  assign free     = !run_valid || run_ready;
  assign hs       = run_valid && run_ready;
  assign same     = pix_color == cur_color;
  assign last_pix = pix_idx == LAST_IDX;
  assign busy     = state != IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pix_ready = 1'b0;
    acc       = 1'b0;
    go        = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          go       = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        pix_ready = free;
        acc       = pix_valid && free;
        // A colour change closes the open run.
        load      = acc && open && !same;
        if (acc && last_pix) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (free) begin
          load      = 1'b1;
          load_last = 1'b1;
          state_nx  = DRAIN;
        end
      end
      DRAIN: begin
        if (hs) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      open      <= 1'b0;
      pix_idx   <= '0;
      cur_start <= '0;
      cur_end   <= '0;
      cur_color <= '0;
      run_valid <= 1'b0;
      run_start <= '0;
      run_end   <= '0;
      run_color <= '0;
      run_last  <= 1'b0;
      run_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= fin;

      if (go) begin
        run_count <= '0;
      end else if (hs) begin
        run_count <= run_count + ADDR_W'(1);
      end

      if (go) begin
        pix_idx <= '0;
        open    <= 1'b0;
      end else if (acc) begin
        // Index saturates at the last pixel; FLUSH follows.
        if (!last_pix) begin
          pix_idx <= pix_idx + ADDR_W'(1);
        end
        if (!open || !same) begin
          open      <= 1'b1;
          cur_start <= pix_idx;
          cur_end   <= pix_idx;
          cur_color <= pix_color;
        end else begin
          cur_end <= pix_idx;
        end
      end

      if (load) begin
        run_valid <= 1'b1;
        run_start <= cur_start;
        run_end   <= cur_end;
        run_color <= cur_color;
        run_last  <= load_last;
      end else if (hs) begin
        run_valid <= 1'b0;
        run_last  <= 1'b0;
      end
    end
  end

endmodule
